// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//   Upstream feeder for the 8-bit CPU instruction path. Receives PROG_LEN
//   program bytes followed by one checksum byte over a valid/ready handshake,
//   buffers the program, and, if the 8-bit wrap-around sum of all PROG_LEN+1
//   bytes is zero, streams the buffer into the CPU (cpu_load/cpu_data) for
//   exactly PROG_LEN back-to-back cycles before releasing the CPU to run.
//
// Ports
//   clock      : system clock, rising edge
//   reset      : synchronous active-low reset
//   start      : single-cycle request to begin a (re)load
//   in_data    : incoming program or checksum byte
//   in_valid   : in_data valid this cycle
//   in_ready   : loader accepts in_data this cycle
//   cpu_load   : CPU Load strobe, high only while streaming
//   cpu_data   : CPU data_in, instruction byte for this cycle
//   busy       : receiving or streaming
//   done       : program loaded, CPU running
//   error      : checksum failed
//   byte_count : bytes accepted in the current load, checksum included
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int PROG_LEN = 32,
    parameter int CW       = 6
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          cpu_load,
    output logic [7:0]    cpu_data,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [CW-1:0] byte_count
);

    localparam int            AW      = $clog2(PROG_LEN);
    localparam logic [CW-1:0] LP_LEN  = CW'(PROG_LEN);
    localparam logic [CW-1:0] LP_FULL = CW'(PROG_LEN + 1);
    localparam logic [CW-1:0] LP_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RECEIVE = 3'd1,
        S_STREAM  = 3'd2,
        S_RUN     = 3'd3,
        S_ERROR   = 3'd4
    } state_t;

    // 8-bit wrap-around accumulation used for both running sum and checksum test
    function automatic logic [7:0] f_add8(input logic [7:0] a, input logic [7:0] b);
        f_add8 = a + b;
    endfunction

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_buf [PROG_LEN];
    logic [7:0]    r_sum;
    logic [CW-1:0] r_idx;
    logic [CW-1:0] r_byte_count;
    logic          r_in_ready;
    logic          r_cpu_load;
    logic [7:0]    r_cpu_data;
    logic          r_busy;
    logic          r_done;
    logic          r_error;

    logic          w_xfer;
    logic          w_wr_en;
    logic [7:0]    w_sum_nxt;
    logic [7:0]    w_sum_chk;
    logic [CW-1:0] w_idx_nxt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_cpu_load_nxt;
    logic [7:0]    w_cpu_data_nxt;

    // A byte moves only when the registered in_ready meets in_valid
    assign w_xfer    = in_valid & r_in_ready;
    assign w_sum_chk = f_add8(r_sum, in_data);

    // Next-state, datapath updates and next values of the registered outputs
    always_comb begin
        w_state_nxt    = r_state;
        w_sum_nxt      = r_sum;
        w_idx_nxt      = r_idx;
        w_cnt_nxt      = r_byte_count;
        w_wr_en        = 1'b0;
        w_cpu_load_nxt = 1'b0;
        w_cpu_data_nxt = 8'h00;
        case (r_state)
            S_IDLE, S_RUN, S_ERROR: begin
                if (start) begin
                    w_state_nxt = S_RECEIVE;
                    w_sum_nxt   = 8'h00;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_RECEIVE: begin
                if (w_xfer) begin
                    if (r_byte_count < LP_LEN) begin
                        w_wr_en   = 1'b1;
                        w_sum_nxt = w_sum_chk;
                        w_cnt_nxt = r_byte_count + LP_ONE;
                    end else begin
                        // Checksum byte: count it, then verify
                        w_cnt_nxt = (r_byte_count < LP_FULL) ? (r_byte_count + LP_ONE) : r_byte_count;
                        if (w_sum_chk == 8'h00) begin
                            // Present buf[0] already on the first STREAM cycle
                            w_state_nxt    = S_STREAM;
                            w_cpu_load_nxt = 1'b1;
                            w_cpu_data_nxt = r_buf[0];
                            w_idx_nxt      = LP_ONE;
                        end else begin
                            w_state_nxt = S_ERROR;
                        end
                    end
                end else begin
                    w_state_nxt = S_RECEIVE;
                end
            end
            S_STREAM: begin
                // r_idx is the index of the byte to present next cycle
                if (r_idx == LP_LEN) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_cpu_load_nxt = 1'b1;
                    w_cpu_data_nxt = r_buf[r_idx[AW-1:0]];
                    w_idx_nxt      = r_idx + LP_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_sum        <= 8'h00;
            r_idx        <= '0;
            r_byte_count <= '0;
            r_in_ready   <= 1'b0;
            r_cpu_load   <= 1'b0;
            r_cpu_data   <= 8'h00;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sum        <= w_sum_nxt;
            r_idx        <= w_idx_nxt;
            r_byte_count <= w_cnt_nxt;
            r_in_ready   <= (w_state_nxt == S_RECEIVE);
            r_cpu_load   <= w_cpu_load_nxt;
            r_cpu_data   <= w_cpu_data_nxt;
            r_busy       <= (w_state_nxt == S_RECEIVE) || (w_state_nxt == S_STREAM);
            r_done       <= (w_state_nxt == S_RUN);
            r_error      <= (w_state_nxt == S_ERROR);
        end
    end

    // Program buffer; contents are don't-care after reset
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_buf[r_byte_count[AW-1:0]] <= in_data;
        end
    end

    assign in_ready   = r_in_ready;
    assign cpu_load   = r_cpu_load;
    assign cpu_data   = r_cpu_data;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;
    assign byte_count = r_byte_count;

endmodule
